// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the register-file requesters and the write-port arbiter.
// The master side holds the requesters and the busy flag; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
);
    logic [3:0]          req;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_data;
    logic                rf_busy;
    logic [3:0]          ack;
    logic                wr_en;
    logic [1:0]          wr_sel;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [7:0]          busy_cycles;

    modport master (
        output req, req_addr, req_data, rf_busy,
        input  ack, wr_en, wr_sel, wr_addr, wr_data, busy_cycles
    );

    modport slave (
        input  req, req_addr, req_data, rf_busy,
        output ack, wr_en, wr_sel, wr_addr, wr_data, busy_cycles
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Registered round-robin arbiter sharing the single register-file write port among
// four requesters; writes aimed at the hardwired zero register are acked but not committed.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                    clk,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  bus
);
    logic [3:0]        ack_q,     ack_d;
    logic              wr_en_q,   wr_en_d;
    logic [1:0]        wr_sel_q,  wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [7:0]        busy_q,    busy_d;
    logic [1:0]        ptr_q,     ptr_d;

    logic [3:0]        eligible;
    logic [1:0]        idx;
    logic [1:0]        win;
    logic              found;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;

    always_comb begin
        // The requester acked this cycle is masked so it cannot win twice in a row.
        eligible = bus.req & ~ack_q;
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant    = found & ~bus.rf_busy;
        win_addr = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];

        ack_d     = '0;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ptr_d     = ptr_q;
        if (grant) begin
            ack_d[win] = 1'b1;
            wr_en_d    = (win_addr != ADDR_W'(ZERO_REG));
            wr_sel_d   = win;
            wr_addr_d  = win_addr;
            wr_data_d  = bus.req_data[int'(win)*DATA_W +: DATA_W];
            ptr_d      = win + 2'd1;
        end

        busy_d = busy_q;
        if (bus.rf_busy && (|bus.req) && (busy_q != 8'hFF)) begin
            busy_d = busy_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            ptr_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_sel      = wr_sel_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy_cycles = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, rotation, alternation,
// zero-register suppression, busy stall/saturation and asynchronous reset kill.
module tb_regfile_write_arbiter;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(
        .DATA_W  (64),
        .ADDR_W  (5),
        .ZERO_REG(31)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.rf_busy = 1'b0;
        bus.req     = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*5 +: 5]   = 5'(i + 1);
            bus.req_data[i*64 +: 64] = 64'h100 + 64'(i);
        end
        tick();
        tick();
        n_checks++;
        if ({bus.ack, bus.wr_en, bus.wr_sel} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack/wr_en/wr_sel=%b expected 0", {bus.ack, bus.wr_en, bus.wr_sel});
        end
        n_checks++;
        if (bus.wr_addr !== 5'd0 || bus.wr_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_bus: wr_addr=%0d wr_data=%h expected 0", bus.wr_addr, bus.wr_data);
        end
        n_checks++;
        if (bus.busy_cycles !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_busy: busy_cycles=%0d expected 0", bus.busy_cycles);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (bus.ack !== 4'b0001 || bus.wr_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: ack=%b wr_sel=%0d expected 0001/0", bus.ack, bus.wr_sel);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack;
        // Requester 0 was just acked; each requester drops req after its ack.
        for (int g = 1; g < 4; g++) begin
            bus.req[g-1] = 1'b0;
            tick();
            exp_ack = 4'b0001 << g;
            n_checks++;
            if (bus.ack !== exp_ack || bus.wr_sel !== 2'(g) || bus.wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_grant%0d: ack=%b wr_sel=%0d wr_en=%b expected %b/%0d/1",
                         g, bus.ack, bus.wr_sel, bus.wr_en, exp_ack, g);
            end
            n_checks++;
            if (bus.wr_addr !== 5'(g + 1) || bus.wr_data !== 64'h100 + 64'(g)) begin
                n_fail++;
                $display("FAIL rr_data%0d: wr_addr=%0d wr_data=%h expected %0d/%h",
                         g, bus.wr_addr, bus.wr_data, g + 1, 64'h100 + 64'(g));
            end
        end
        bus.req = 4'b0000;
        tick();
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle: ack=%b wr_en=%b expected 0000/0", bus.ack, bus.wr_en);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0100;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b0010;
        bus.req = 4'b0100;
        for (int s = 0; s < 4; s++) begin
            tick();
            bus.req = 4'b0110;
            n_checks++;
            if (bus.ack !== exp_seq[s]) begin
                n_fail++;
                $display("FAIL b2b_step%0d: ack=%b expected %b", s, bus.ack, exp_seq[s]);
            end
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_zero_reg();
        bus.req_addr[3*5 +: 5]    = 5'd31;
        bus.req_data[3*64 +: 64]  = 64'hDEAD;
        bus.req = 4'b1000;
        tick();
        n_checks++;
        if (bus.ack !== 4'b1000 || bus.wr_sel !== 2'd3 || bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_suppress: ack=%b wr_sel=%0d wr_en=%b expected 1000/3/0",
                     bus.ack, bus.wr_sel, bus.wr_en);
        end
        bus.req = 4'b0000;
        bus.req_addr[3*5 +: 5] = 5'd5;
        tick();
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.wr_sel !== 2'd3 || bus.wr_addr !== 5'd31) begin
            n_fail++;
            $display("FAIL zero_reg_hold: ack=%b wr_sel=%0d wr_addr=%0d expected 0000/3/31",
                     bus.ack, bus.wr_sel, bus.wr_addr);
        end
        bus.req = 4'b1000;
        tick();
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL zero_reg_normal: wr_en=%b wr_addr=%0d wr_data=%h expected 1/5/dead",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_busy_stall();
        bus.req     = 4'b0010;
        bus.rf_busy = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.busy_cycles !== 8'd3) begin
            n_fail++;
            $display("FAIL busy_stall: ack=%b busy_cycles=%0d expected 0000/3", bus.ack, bus.busy_cycles);
        end
        bus.rf_busy = 1'b0;
        tick();
        n_checks++;
        if (bus.ack !== 4'b0010 || bus.busy_cycles !== 8'd3) begin
            n_fail++;
            $display("FAIL busy_release: ack=%b busy_cycles=%0d expected 0010/3", bus.ack, bus.busy_cycles);
        end
        bus.req = 4'b0000;
        tick();
        bus.req     = 4'b0001;
        bus.rf_busy = 1'b1;
        repeat (252) tick();
        n_checks++;
        if (bus.busy_cycles !== 8'd255) begin
            n_fail++;
            $display("FAIL busy_reach_max: busy_cycles=%0d expected 255", bus.busy_cycles);
        end
        repeat (48) tick();
        n_checks++;
        if (bus.busy_cycles !== 8'd255 || bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL busy_saturate: busy_cycles=%0d ack=%b expected 255/0000",
                     bus.busy_cycles, bus.ack);
        end
        bus.rf_busy = 1'b0;
        tick();
        n_checks++;
        if (bus.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL busy_after_sat: ack=%b expected 0001", bus.ack);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_write();
        bus.req_addr[0*5 +: 5] = 5'd7;
        bus.req = 4'b0001;
        tick();
        n_checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7) begin
            n_fail++;
            $display("FAIL midrst_setup: wr_en=%b wr_addr=%0d expected 1/7", bus.wr_en, bus.wr_addr);
        end
        bus.req = 4'b0000;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.ack !== 4'b0000 || bus.wr_addr !== 5'd0 || bus.busy_cycles !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_async: wr_en=%b ack=%b wr_addr=%0d busy=%0d expected 0/0000/0/0",
                     bus.wr_en, bus.ack, bus.wr_addr, bus.busy_cycles);
        end
        bus.req = 4'b1001;
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (bus.ack !== 4'b0001 || bus.wr_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_ptr: ack=%b wr_sel=%0d expected 0001/0", bus.ack, bus.wr_sel);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_zero_reg();
        test_busy_stall();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
